delay_argmax: RTL

- Timing-analysis stage downstream of the guess sequencer's delay counter.
- Consumes one measured reply delay per transaction, tagged with the guess byte that produced it.
- Sums TRIALS delays per guess byte and sweeps GUESS_MIN..GUESS_MAX.
- Reports the byte with the largest summed delay, the runner-up sum, and a confidence flag, so the sequencer can commit the byte or re-sweep.

---
 rtl/delay_argmax.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/delay_argmax.sv
// delay_argmax
//   Accumulates TRIALS reply delays per guess byte while the guess sequencer
//   sweeps GUESS_MIN..GUESS_MAX, then reports the byte with the largest summed
//   delay, the runner-up sum and a confidence flag.
//
// Ports
//   CLK_50, RST_N        clock (rising edge), synchronous active-low reset
//   start, abort         begin a sweep (IDLE/DONE only) / cancel to IDLE
//   sample_valid/ready   sample handshake, ready only while accumulating
//   sample_delay/guess   measured delay and the guess byte it belongs to
//   busy                 accumulating or comparing
//   expected_guess       guess byte currently being accumulated
//   result_valid         high while results are held in DONE
//   result_byte          guess byte with the largest sum
//   result_confident     best_sum - runner_sum >= MARGIN
//   best_sum/runner_sum  largest and second-largest sums
//   seq_error            sticky: a sample arrived with the wrong guess tag
module delay_argmax #(
  parameter int         DELAY_W   = 24,
  parameter int         TRIALS    = 4,
  parameter int         SUM_W     = DELAY_W + $clog2(TRIALS),
  parameter int         MARGIN    = 16,
  parameter logic [7:0] GUESS_MIN = 8'h06,
  parameter logic [7:0] GUESS_MAX = 8'hFF
) (
  input  logic               CLK_50,
  input  logic               RST_N,
  input  logic               start,
  input  logic               abort,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [DELAY_W-1:0] sample_delay,
  input  logic [7:0]         sample_guess,
  output logic               busy,
  output logic [7:0]         expected_guess,
  output logic               result_valid,
  output logic [7:0]         result_byte,
  output logic               result_confident,
  output logic [SUM_W-1:0]   best_sum,
  output logic [SUM_W-1:0]   runner_sum,
  output logic               seq_error
);

  // Trial counter needs at least one bit even when TRIALS == 1.
  localparam int CNT_W = (TRIALS > 1) ? $clog2(TRIALS) : 1;
  localparam logic [CNT_W-1:0] LAST_TRIAL = CNT_W'(TRIALS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

  state_t             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   trial_cnt_q, trial_cnt_d;
  logic [SUM_W-1:0]   best_q, best_d;
  logic [SUM_W-1:0]   runner_q, runner_d;
  logic [7:0]         byte_q, byte_d;
  logic [7:0]         guess_q, guess_d;
  logic               conf_q, conf_d;
  logic               seq_err_q, seq_err_d;

  logic [SUM_W-1:0]   new_best, new_runner;
  logic [7:0]         new_byte;
  logic               xfer;

  // Ranking update applied in COMPARE. Strict compares keep the earlier
  // (lower) guess on a tie.
  always_comb begin
    new_best   = best_q;
    new_runner = runner_q;
    new_byte   = byte_q;
    if (acc_q > best_q) begin
      new_best   = acc_q;
      new_runner = best_q;
      new_byte   = guess_q;
    end else if (acc_q > runner_q) begin
      new_runner = acc_q;
    end
  end

  assign xfer = sample_valid && (state_q == ACCUM);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    trial_cnt_d = trial_cnt_q;
    best_d      = best_q;
    runner_d    = runner_q;
    byte_d      = byte_q;
    guess_d     = guess_q;
    conf_d      = conf_q;
    seq_err_d   = seq_err_q;

    if (abort) begin
      // Results stay in place; only the next start clears them.
      state_d = IDLE;
    end else if (start && (state_q == IDLE || state_q == DONE)) begin
      state_d     = ACCUM;
      acc_d       = '0;
      trial_cnt_d = '0;
      best_d      = '0;
      runner_d    = '0;
      byte_d      = GUESS_MIN;
      guess_d     = GUESS_MIN;
      conf_d      = 1'b0;
      seq_err_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (xfer) begin
            if (sample_guess == guess_q) begin
              acc_d       = acc_q + SUM_W'(sample_delay);
              trial_cnt_d = trial_cnt_q + 1'b1;
              if (trial_cnt_q == LAST_TRIAL) state_d = COMPARE;
            end else begin
              seq_err_d = 1'b1;
            end
          end
        end
        COMPARE: begin
          best_d      = new_best;
          runner_d    = new_runner;
          byte_d      = new_byte;
          acc_d       = '0;
          trial_cnt_d = '0;
          if (guess_q == GUESS_MAX) begin
            // Stop at the top byte without incrementing so it cannot wrap.
            state_d = DONE;
            conf_d  = (new_best - new_runner) >= SUM_W'(MARGIN);
          end else begin
            guess_d = guess_q + 8'd1;
            state_d = ACCUM;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      trial_cnt_q <= '0;
      best_q      <= '0;
      runner_q    <= '0;
      byte_q      <= GUESS_MIN;
      guess_q     <= GUESS_MIN;
      conf_q      <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      trial_cnt_q <= trial_cnt_d;
      best_q      <= best_d;
      runner_q    <= runner_d;
      byte_q      <= byte_d;
      guess_q     <= guess_d;
      conf_q      <= conf_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign sample_ready     = (state_q == ACCUM);
  assign busy             = (state_q == ACCUM) || (state_q == COMPARE);
  assign result_valid     = (state_q == DONE);
  assign expected_guess   = guess_q;
  assign result_byte      = byte_q;
  assign result_confident = conf_q;
  assign best_sum         = best_q;
  assign runner_sum       = runner_q;
  assign seq_error        = seq_err_q;

endmodule
